// File: rtl/asin_lut_search.sv
// Inverse sine lookup: binary search for the largest angle index whose
// LUT value does not exceed the requested sine magnitude.
module asin_lut_search #(
    parameter int unsigned DEG_W   = 10,
    parameter int unsigned VAL_W   = 10,
    parameter int unsigned MAX_DEG = 899,
    parameter int unsigned LUT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEG_W-1:0] out_degree,
    output logic [DEG_W-1:0] lut_degree,
    input  logic [VAL_W-1:0] lut_value
);

    localparam int unsigned CNT_W = (LUT_LAT < 2) ? 1 : $clog2(LUT_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DEG_W-1:0] lo_q, lo_d;
    logic [DEG_W-1:0] hi_q, hi_d;
    logic [VAL_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [DEG_W-1:0] out_degree_q, out_degree_d;
    logic [DEG_W-1:0] lut_degree_q, lut_degree_d;
    logic [DEG_W:0]   sum_c;
    logic [DEG_W-1:0] mid_c;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_degree = out_degree_q;
    assign lut_degree = lut_degree_q;

    // State and datapath registers; reset aborts any search in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            target_q     <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_degree_q <= '0;
            lut_degree_q <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_degree_q <= out_degree_d;
            lut_degree_q <= lut_degree_d;
        end
    end

    // Search sequencing; mid rounds up so lo=mid always makes progress.
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_degree_d = out_degree_q;
        lut_degree_d = lut_degree_q;
        sum_c        = {1'b0, lo_q} + {1'b0, hi_q} + (DEG_W + 1)'(1);
        mid_c        = sum_c[DEG_W:1];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    target_d   = in_value;
                    lo_d       = '0;
                    hi_d       = DEG_W'(MAX_DEG);
                    in_ready_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lo_q == hi_q) begin
                    out_degree_d = lo_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    lut_degree_d = mid_c;
                    cnt_d        = CNT_W'(LUT_LAT);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (lut_value <= target_q) begin
                    lo_d = lut_degree_q;
                end else begin
                    hi_d = lut_degree_q - DEG_W'(1);
                end
                state_d = S_ISSUE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
